key_fifo_rpt: RTL and testbench
===============================

Name: key_fifo_rpt

Overview:
- Parametrised keyboard input queue with typematic auto-repeat, sitting between the PS/2 scan-to-ASCII decoder and the CPU MMIO read port.
- Works in a single clock domain. The decoder presents the current held key, qualified by a sample strobe.
- Adds explicit empty/full/level status, a sticky overflow flag, a software clear and configurable repeat timing on top of the existing key buffering.

Parameters:
- DATA_W, 8, width of key code; code 0 means "no key".
- DEPTH, 64, FIFO entries; must be a power of 2, at least 2.
- DELAY_TICKS, 300000, sample strobes a key must stay held before the first repeat.
- RATE_TICKS, 30000, sample strobes between subsequent repeats.
- REPEAT_EN, 1, 0 disables auto-repeat: one push per press.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sample_en  in  1  qualifies ascii_key; all repeat timing counts only these cycles.
- ascii_key  in  DATA_W  currently held key, 0 = released.
- will_read  in  1  CPU pop request, one per cycle.
- clear  in  1  synchronous flush of FIFO and overflow flag.
- cpu_data  out  DATA_W  popped key, registered.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds DEPTH entries.
- level  out  $clog2(DEPTH)+1  current entry count.
- overflow  out  1  sticky: a push was dropped.

Behaviour:
- Reset (rst=1 at posedge):
  - head, tail and level go to 0; cpu_data=0; overflow=0; empty=1; full=0.
  - State goes to IDLE; counter=0; prev_key=0.
  - Memory contents are don't-care.
- clear has the same effect as reset on the FIFO, overflow and cpu_data. The repeat FSM is not affected. clear has priority over push and pop in the same cycle.
- Storage: DEPTH x DATA_W array. Pointers are $clog2(DEPTH) bits wide and wrap naturally.
  - full = (level==DEPTH); empty = (level==0).
  - level, full and empty update in the cycle after the push/pop edge.
- Pop:
  - On posedge with will_read=1 and !empty: cpu_data <= mem[head]; head increments.
  - will_read=1 while empty: cpu_data <= 0; pointers are unchanged.
  - will_read=0: cpu_data holds its value.
  - Latency is 1 cycle from will_read to valid cpu_data.
- Push: an internal one-cycle push_req generated by the FSM writes ascii_key at tail.
  - Not full: accepted.
  - Full and pop in the same cycle: push accepted; level unchanged.
  - Full and no pop: push dropped; overflow <= 1, held until rst or clear.
  - Push and pop in the same cycle with level 1..DEPTH-1: both happen; level unchanged.
  - Push and pop in the same cycle while empty: push accepted; pop returns 0 (no bypass).
- Repeat FSM: advances only on cycles with sample_en=1. When sample_en=0, state, counter and prev_key all hold.
  - IDLE:
    - ascii_key!=0: push_req; prev_key<=ascii_key; counter<=0; go to DELAY.
  - DELAY:
    - ascii_key==0: go to IDLE.
    - ascii_key!=prev_key (nonzero): push_req for the new key; prev_key updated; counter<=0; stay in DELAY.
    - Same key and counter==DELAY_TICKS-1: push_req; counter<=0; go to REPEAT if REPEAT_EN, otherwise go to HOLD.
    - Otherwise: counter increments.
  - REPEAT:
    - Release and key-change handling as in DELAY; a key change returns to DELAY.
    - Same key and counter==RATE_TICKS-1: push_req; counter<=0.
    - Otherwise: counter increments.
  - HOLD: no pushes until release (go to IDLE) or key change (push, go to DELAY).
  - When REPEAT_EN=0, the DELAY-expiry push is suppressed.
- Counter width is $clog2(max(DELAY_TICKS,RATE_TICKS)). Compares are equality; no overflow is possible.
- rst in the middle of a hold returns the FSM to IDLE. If the key is still held when rst drops, the next sample pushes it once, as a new press.

Test Plan (DEPTH=4, DELAY_TICKS=3, RATE_TICKS=2, sample_en=1 unless stated):
- Reset then read:
  - Stimulus: rst 2 cycles, then will_read=1 for 1 cycle.
  - Required: cpu_data=0, empty=1, level=0, overflow=0.
- Press/release:
  - Stimulus: ascii_key=0x41 for 1 sample, then 0; then will_read.
  - Required: level=1 after push; cpu_data=0x41 one cycle after will_read; then empty=1.
- Typematic:
  - Stimulus: hold 0x61 for 8 samples, no reads.
  - Required: pushes at samples 1, 4, 6 and 8; level=4; full=1; overflow=0.
- Overflow:
  - Stimulus: continue the previous hold 2 more samples.
  - Required: push dropped; overflow=1; level=4. Then clear: level=0, overflow=0, empty=1.
- Key change and sample gating:
  - Stimulus: 0x31 for 1 sample, then 0x32 with sample_en toggling 1/0 for 4 cycles.
  - Required: exactly two pushes (0x31, 0x32); counter advances only on strobe cycles.
- Simultaneous push/pop at full:
  - Stimulus: FIFO full with keys A B C D; push E with will_read=1 in the same cycle.
  - Required: cpu_data=A; level stays 4; overflow=0; subsequent reads return B C D E.

Source files
------------

// File: rtl/key_fifo_rpt_if.sv
// Keyboard queue bus: decoder-side key/strobe inputs, CPU pop port and queue status.
interface key_fifo_rpt_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 64
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              sample_en;
  logic [DATA_W-1:0] ascii_key;
  logic              will_read;
  logic              clear;
  logic [DATA_W-1:0] cpu_data;
  logic              empty;
  logic              full;
  logic [LVL_W-1:0]  level;
  logic              overflow;

  modport master (
    output sample_en, ascii_key, will_read, clear,
    input  cpu_data, empty, full, level, overflow
  );

  modport slave (
    input  sample_en, ascii_key, will_read, clear,
    output cpu_data, empty, full, level, overflow
  );
endinterface

// File: rtl/key_fifo_rpt.sv
// Keyboard input FIFO with typematic auto-repeat between the key decoder and CPU MMIO read.
// Repeat timing advances only on sample_en cycles; clear flushes the queue but not the repeat FSM.
module key_fifo_rpt #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned DELAY_TICKS = 300000,
  parameter int unsigned RATE_TICKS  = 30000,
  parameter bit          REPEAT_EN   = 1'b1
) (
  input logic         clk,
  input logic         rst,
  key_fifo_rpt_if.slave kb
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned MAX_T = (DELAY_TICKS > RATE_TICKS) ? DELAY_TICKS : RATE_TICKS;
  localparam int unsigned CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_TICKS - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_TICKS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_prev_key;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [LVL_W-1:0]  r_level;
  logic [DATA_W-1:0] r_cpu_data;
  logic              r_empty;
  logic              r_full;
  logic              r_overflow;

  logic              w_key_nz;
  logic              w_key_same;
  logic              w_push;
  logic              w_pop;
  logic              w_push_acc;
  logic [LVL_W-1:0]  w_level_nxt;

  assign w_key_nz   = |kb.ascii_key;
  assign w_key_same = (kb.ascii_key == r_prev_key);

  // Push request: new press, key change, or repeat-counter expiry on a strobe cycle.
  always_comb begin
    w_push = 1'b0;
    if (kb.sample_en && w_key_nz) begin
      case (r_state)
        ST_IDLE:   w_push = 1'b1;
        ST_DELAY:  w_push = !w_key_same || ((r_cnt == DELAY_LAST) && REPEAT_EN);
        ST_REPEAT: w_push = !w_key_same || (r_cnt == RATE_LAST);
        ST_HOLD:   w_push = !w_key_same;
        default:   w_push = 1'b0;
      endcase
    end
  end

  // Repeat FSM; frozen on cycles without a sample strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_prev_key <= '0;
    end else if (kb.sample_en) begin
      case (r_state)
        ST_IDLE: begin
          if (w_key_nz) begin
            r_prev_key <= kb.ascii_key;
            r_cnt      <= '0;
            r_state    <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (!w_key_nz) begin
            r_state <= ST_IDLE;
          end else if (!w_key_same) begin
            r_prev_key <= kb.ascii_key;
            r_cnt      <= '0;
          end else if (r_cnt == DELAY_LAST) begin
            r_cnt   <= '0;
            r_state <= REPEAT_EN ? ST_REPEAT : ST_HOLD;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (!w_key_nz) begin
            r_state <= ST_IDLE;
          end else if (!w_key_same) begin
            r_prev_key <= kb.ascii_key;
            r_cnt      <= '0;
            r_state    <= ST_DELAY;
          end else if (r_cnt == RATE_LAST) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (!w_key_nz) begin
            r_state <= ST_IDLE;
          end else if (!w_key_same) begin
            r_prev_key <= kb.ascii_key;
            r_cnt      <= '0;
            r_state    <= ST_DELAY;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A full queue still accepts a push when a pop frees a slot in the same cycle.
  assign w_pop       = kb.will_read & ~r_empty;
  assign w_push_acc  = w_push & (~r_full | w_pop);
  assign w_level_nxt = r_level + LVL_W'(w_push_acc) - LVL_W'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push_acc && !rst && !kb.clear) begin
      r_mem[r_tail] <= kb.ascii_key;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || kb.clear) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_level    <= '0;
      r_cpu_data <= '0;
      r_overflow <= 1'b0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
    end else begin
      if (kb.will_read) begin
        r_cpu_data <= w_pop ? r_mem[r_head] : '0;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      if (w_push_acc) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_push && !w_push_acc) begin
        r_overflow <= 1'b1;
      end
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == LVL_FULL);
    end
  end

  assign kb.cpu_data = r_cpu_data;
  assign kb.empty    = r_empty;
  assign kb.full     = r_full;
  assign kb.level    = r_level;
  assign kb.overflow = r_overflow;

endmodule

// File: tb/tb_key_fifo_rpt.sv
// Bench for key_fifo_rpt: directed vector table, hand-written corner sequences,
// then random stimulus against a hold-count/queue reference model.
module tb_key_fifo_rpt;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DT    = 3;
  localparam int unsigned RT    = 2;
  localparam bit          RPT   = 1'b1;

  logic clk = 1'b0;
  logic rst;

  key_fifo_rpt_if #(.DATA_W(DW), .DEPTH(DEPTH)) kb ();

  key_fifo_rpt #(
    .DATA_W(DW), .DEPTH(DEPTH), .DELAY_TICKS(DT), .RATE_TICKS(RT), .REPEAT_EN(RPT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kb (kb)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       se;
    logic [7:0] key;
    logic       rd;
    logic       clr;
    logic [7:0] e_cpu;
    int         e_lvl;
    logic       e_ovf;
    logic       e_emp;
    logic       e_full;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mv(logic r, logic se, logic [7:0] k, logic rd, logic cl,
                              logic [7:0] c, int l, logic o, logic e, logic f);
    vec_t v;
    v.rst = r; v.se = se; v.key = k; v.rd = rd; v.clr = cl;
    v.e_cpu = c; v.e_lvl = l; v.e_ovf = o; v.e_emp = e; v.e_full = f;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int c, input int l, input int o,
                         input int e, input int f);
    chk($sformatf("%s.cpu_data", nm), int'(kb.cpu_data), c);
    chk($sformatf("%s.level", nm),    int'(kb.level),    l);
    chk($sformatf("%s.overflow", nm), int'(kb.overflow), o);
    chk($sformatf("%s.empty", nm),    int'(kb.empty),    e);
    chk($sformatf("%s.full", nm),     int'(kb.full),     f);
  endtask

  // Apply one cycle of inputs at negedge; return 1 time unit after the posedge.
  task automatic drive(input logic r, input logic se, input logic [7:0] k,
                       input logic rd, input logic cl);
    @(negedge clk);
    rst          = r;
    kb.sample_en = se;
    kb.ascii_key = k;
    kb.will_read = rd;
    kb.clear     = cl;
    @(posedge clk);
    #1;
  endtask

  // Reference model: keys pushed by how long the same key has been held.
  logic [7:0] m_q[$];
  logic [7:0] m_cpu;
  logic       m_ovf;
  logic [7:0] m_prev;
  int         hold_n;

  task automatic model_step(input logic r, input logic se, input logic [7:0] k,
                            input logic rd, input logic cl);
    logic push;
    logic pop;
    int   sz;
    if (r) begin
      m_q.delete();
      m_cpu = 8'h00; m_ovf = 1'b0; hold_n = 0; m_prev = 8'h00;
      return;
    end
    push = 1'b0;
    if (se) begin
      if (k == 8'h00) begin
        hold_n = 0;
      end else begin
        if (hold_n > 0 && k == m_prev) hold_n++;
        else hold_n = 1;
        m_prev = k;
        push = (hold_n == 1) ||
               (RPT && hold_n > int'(DT) && ((hold_n - 1 - int'(DT)) % int'(RT)) == 0);
      end
    end
    if (cl) begin
      m_q.delete();
      m_cpu = 8'h00; m_ovf = 1'b0;
    end else begin
      sz  = m_q.size();
      pop = rd && (sz > 0);
      if (rd) m_cpu = pop ? m_q.pop_front() : 8'h00;
      if (push) begin
        if (sz < int'(DEPTH) || pop) m_q.push_back(k);
        else m_ovf = 1'b1;
      end
    end
  endtask

  logic [7:0] keys [4] = '{8'h00, 8'h41, 8'h42, 8'h43};

  initial begin
    rst = 1'b1;
    kb.sample_en = 1'b0; kb.ascii_key = 8'h00; kb.will_read = 1'b0; kb.clear = 1'b0;

    //        rst se key   rd clr  cpu   lvl ovf emp full
    vt.push_back(mv(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0));
    vt.push_back(mv(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0));
    vt.push_back(mv(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0));
    vt.push_back(mv(0, 1, 8'h41, 0, 0, 8'h00, 1, 0, 0, 0));
    vt.push_back(mv(0, 1, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0));
    vt.push_back(mv(0, 0, 8'h00, 1, 0, 8'h41, 0, 0, 1, 0));
    vt.push_back(mv(0, 0, 8'h00, 0, 0, 8'h41, 0, 0, 1, 0));
    vt.push_back(mv(0, 1, 8'h61, 0, 0, 8'h41, 1, 0, 0, 0));
    vt.push_back(mv(0, 1, 8'h61, 0, 0, 8'h41, 1, 0, 0, 0));
    vt.push_back(mv(0, 1, 8'h61, 0, 0, 8'h41, 1, 0, 0, 0));
    vt.push_back(mv(0, 1, 8'h61, 0, 0, 8'h41, 2, 0, 0, 0));
    vt.push_back(mv(0, 1, 8'h61, 0, 0, 8'h41, 2, 0, 0, 0));
    vt.push_back(mv(0, 1, 8'h61, 0, 0, 8'h41, 3, 0, 0, 0));
    vt.push_back(mv(0, 1, 8'h61, 0, 0, 8'h41, 3, 0, 0, 0));
    vt.push_back(mv(0, 1, 8'h61, 0, 0, 8'h41, 4, 0, 0, 1));
    vt.push_back(mv(0, 1, 8'h61, 0, 0, 8'h41, 4, 0, 0, 1));
    vt.push_back(mv(0, 1, 8'h61, 0, 0, 8'h41, 4, 1, 0, 1));
    vt.push_back(mv(0, 0, 8'h61, 0, 1, 8'h00, 0, 0, 1, 0));
    vt.push_back(mv(0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0));
    vt.push_back(mv(0, 1, 8'h31, 0, 0, 8'h00, 1, 0, 0, 0));
    vt.push_back(mv(0, 1, 8'h32, 0, 0, 8'h00, 2, 0, 0, 0));
    vt.push_back(mv(0, 0, 8'h32, 0, 0, 8'h00, 2, 0, 0, 0));
    vt.push_back(mv(0, 1, 8'h32, 0, 0, 8'h00, 2, 0, 0, 0));
    vt.push_back(mv(0, 0, 8'h32, 0, 0, 8'h00, 2, 0, 0, 0));
    vt.push_back(mv(0, 1, 8'h32, 0, 0, 8'h00, 2, 0, 0, 0));
    vt.push_back(mv(0, 1, 8'h32, 0, 0, 8'h00, 3, 0, 0, 0));
    vt.push_back(mv(0, 1, 8'h00, 0, 0, 8'h00, 3, 0, 0, 0));
    vt.push_back(mv(0, 0, 8'h00, 1, 0, 8'h31, 2, 0, 0, 0));
    vt.push_back(mv(0, 0, 8'h00, 1, 0, 8'h32, 1, 0, 0, 0));
    vt.push_back(mv(0, 0, 8'h00, 1, 0, 8'h32, 0, 0, 1, 0));
    vt.push_back(mv(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst, vt[i].se, vt[i].key, vt[i].rd, vt[i].clr);
      chk_all($sformatf("vec%0d", i), int'(vt[i].e_cpu), vt[i].e_lvl,
              int'(vt[i].e_ovf), int'(vt[i].e_emp), int'(vt[i].e_full));
    end

    // Fill A..D via key changes, then push E with a pop while full.
    drive(0, 1, 8'h0A, 0, 0);
    drive(0, 1, 8'h0B, 0, 0);
    drive(0, 1, 8'h0C, 0, 0);
    drive(0, 1, 8'h0D, 0, 0);
    chk_all("fill", 0, 4, 0, 0, 1);
    drive(0, 1, 8'h0E, 1, 0);
    chk_all("full_push_pop", 8'h0A, 4, 0, 0, 1);
    drive(0, 1, 8'h00, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    chk_all("drain_b", 8'h0B, 3, 0, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    chk_all("drain_c", 8'h0C, 2, 0, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    chk_all("drain_d", 8'h0D, 1, 0, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    chk_all("drain_e", 8'h0E, 0, 0, 1, 0);

    // Push and pop together while empty: no bypass.
    drive(0, 1, 8'h55, 1, 0);
    chk_all("empty_push_pop", 8'h00, 1, 0, 0, 0);
    drive(0, 1, 8'h00, 1, 0);
    chk_all("empty_push_pop_rd", 8'h55, 0, 0, 1, 0);

    // Reset mid-hold: key still held afterwards counts as a fresh press.
    drive(0, 1, 8'h77, 0, 0);
    chk_all("hold_pre_rst", 8'h55, 1, 0, 0, 0);
    drive(1, 1, 8'h77, 0, 0);
    chk_all("hold_rst", 8'h00, 0, 0, 1, 0);
    drive(0, 1, 8'h77, 0, 0);
    chk_all("hold_post_rst", 8'h00, 1, 0, 0, 0);

    // Random phase against the reference model.
    begin
      logic       r, se, rd, cl;
      logic [7:0] k;
      k = 8'h00;
      drive(1, 0, 8'h00, 0, 0);
      model_step(1, 0, 8'h00, 0, 0);
      for (int n = 0; n < 800; n++) begin
        if ($urandom_range(0, 5) == 0) k = keys[$urandom_range(0, 3)];
        r  = ($urandom_range(0, 199) == 0);
        se = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 2) == 0);
        cl = ($urandom_range(0, 49) == 0);
        model_step(r, se, k, rd, cl);
        drive(r, se, k, rd, cl);
        chk_all($sformatf("rnd%0d", n), int'(m_cpu), m_q.size(), int'(m_ovf),
                int'(m_q.size() == 0), int'(m_q.size() == int'(DEPTH)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
